axis_multi_phase_generator: RTL and testbench

//  Multi-channel successor to the single-stick phase generator. Holds NUM_CH phase

---
 rtl/axis_multi_phase_generator.sv | 167 ++++++++++++++++
 tb/tb_axis_multi_phase_generator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_multi_phase_generator.sv
// Multi-channel phase generator.
// One accumulator per channel advances on each sample tick. Each advance is
// followed by one AXI-Stream burst of NUM_CH beats, tagged by channel. One
// tick may queue while a burst is in flight; any further tick is dropped and
// raises the sticky overrun flag.
module axis_multi_phase_generator #(
  parameter int NUM_CH           = 2,
  parameter int PHASE_WIDTH      = 15,
  parameter int INC_WIDTH        = 13,
  parameter int AXIS_TDATA_WIDTH = 24
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_CH*INC_WIDTH-1:0]   cfg_inc,
  input  logic                          tick,
  input  logic                          overrun_clr,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          overrun
);

  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);
  localparam logic [CH_BITS-1:0] CH_ONE  = CH_BITS'(1);
  localparam logic [CH_BITS-1:0] CH_ZERO = CH_BITS'(0);

  logic [0:0]                  state_q,   state_d;
  logic [CH_BITS-1:0]          ch_idx_q,  ch_idx_d;
  logic                        pending_q, pending_d;
  logic [PHASE_WIDTH-1:0]      acc_q [NUM_CH];
  logic [PHASE_WIDTH-1:0]      acc_d [NUM_CH];
  logic                        tvalid_q,  tvalid_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q,   tdata_d;
  logic                        tlast_q,   tlast_d;
  logic                        overrun_q, overrun_d;

  logic                        handshake_s;
  logic                        is_last_s;
  logic                        drop_s;
  logic [CH_BITS-1:0]          ch_next_s;

  // Packs a beat: channel tag directly above the phase, upper bits zero.
  function automatic logic [AXIS_TDATA_WIDTH-1:0] make_beat(
    input logic [CH_BITS-1:0]     ch,
    input logic [PHASE_WIDTH-1:0] ph
  );
    logic [AXIS_TDATA_WIDTH-1:0] b;
    b = '0;
    b[PHASE_WIDTH-1:0]       = ph;
    b[PHASE_WIDTH +: CH_BITS] = ch;
    return b;
  endfunction

  // Next-state logic: advance on tick, stream the burst, queue or drop ticks.
  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    pending_d   = pending_q;
    acc_d       = acc_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    drop_s      = 1'b0;
    handshake_s = tvalid_q & m_axis_tready;
    is_last_s   = (ch_idx_q == LAST_CH);
    ch_next_s   = ch_idx_q + CH_ONE;

    case (state_q)
      ST_IDLE: begin
        // A queued tick and a fresh tick collapse into a single advance.
        if (tick || pending_q) begin
          for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i] + PHASE_WIDTH'(cfg_inc[i*INC_WIDTH +: INC_WIDTH]);
          end
          pending_d = 1'b0;
          ch_idx_d  = CH_ZERO;
          state_d   = ST_EMIT;
          tvalid_d  = 1'b1;
          tdata_d   = make_beat(CH_ZERO, acc_d[0]);
          tlast_d   = (LAST_CH == CH_ZERO);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        // Ticks during a burst: queue the first, drop the rest.
        if (tick) begin
          if (pending_q) begin
            drop_s = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end else begin
          pending_d = pending_q;
        end
        if (handshake_s) begin
          if (is_last_s) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
          end else begin
            ch_idx_d = ch_next_s;
            tdata_d  = make_beat(ch_next_s, acc_q[ch_next_s]);
            tlast_d  = (ch_next_s == LAST_CH);
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
      end
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers with synchronous active-low reset that abandons any burst.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      ch_idx_q  <= CH_ZERO;
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_idx_q  <= ch_idx_d;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
      end
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_axis_multi_phase_generator.sv
// Scoreboard bench for axis_multi_phase_generator (NUM_CH=2 defaults).
module tb_axis_multi_phase_generator;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [25:0] cfg_inc = 26'd0;
  logic        tick = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        tready = 1'b1;
  logic        tvalid;
  logic [23:0] tdata;
  logic        tlast;
  logic        overrun;

  axis_multi_phase_generator #(
    .NUM_CH(2), .PHASE_WIDTH(15), .INC_WIDTH(13), .AXIS_TDATA_WIDTH(24)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_inc(cfg_inc), .tick(tick),
    .overrun_clr(overrun_clr), .m_axis_tready(tready), .m_axis_tvalid(tvalid),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast), .overrun(overrun)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];
  logic [14:0] m_acc0 = 15'd0;
  logic [14:0] m_acc1 = 15'd0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] beat(input logic ch, input logic [14:0] ph);
    return {8'h00, ch, ph};
  endfunction

  task automatic push_exp(input logic [23:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Advance the reference accumulators with the current increments and expect a burst.
  task automatic model_burst();
    m_acc0 = m_acc0 + {2'b00, cfg_inc[12:0]};
    m_acc1 = m_acc1 + {2'b00, cfg_inc[25:13]};
    push_exp(beat(1'b0, m_acc0), 1'b0);
    push_exp(beat(1'b1, m_acc1), 1'b1);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 400) begin
      step(1);
      n++;
    end
    check1("drain", {31'd0, (exp_q.size() == 0 && !tvalid)}, 32'd1);
    step(4);
  endtask

  task automatic do_reset(input int n);
    aresetn = 1'b0;
    step(n);
    check1("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check1("rst_tdata", {8'd0, tdata}, 32'd0);
    check1("rst_tlast", {31'd0, tlast}, 32'd0);
    check1("rst_overrun", {31'd0, overrun}, 32'd0);
    aresetn = 1'b1;
    m_acc0 = 15'd0;
    m_acc1 = 15'd0;
    exp_q.delete();
  endtask

  // Monitor: pop and compare on every handshake; check stability while stalled.
  initial begin
    logic        stall_v;
    logic [23:0] held_d;
    logic        held_l;
    logic [24:0] e;
    stall_v = 1'b0;
    held_d = 24'd0;
    held_l = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall_v = 1'b0;
      end else begin
        if (stall_v) begin
          checks++;
          if (!(tvalid && tdata == held_d && tlast == held_l)) begin
            errors++;
            $display("FAIL hold got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                     tvalid, tdata, tlast, held_d, held_l);
          end
        end
        if (tvalid && tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat got d=%h l=%b expected no beat", tdata, tlast);
          end else begin
            e = exp_q.pop_front();
            if (tdata !== e[23:0] || tlast !== e[24]) begin
              errors++;
              $display("FAIL beat got d=%h l=%b expected d=%h l=%b",
                       tdata, tlast, e[23:0], e[24]);
            end
          end
        end
        stall_v = tvalid && !tready;
        held_d  = tdata;
        held_l  = tlast;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] w0 [5];
    w0 = '{15'h1FFF, 15'h3FFE, 15'h5FFD, 15'h7FFC, 15'h1FFB};
    cfg_inc = {13'h1138, 13'h0EB8};
    step(1);
    do_reset(3);

    // Basic bursts, tick every 100 cycles
    push_exp(24'h000EB8, 1'b0);
    push_exp(24'h009138, 1'b1);
    pulse_tick();
    check1("latency_tvalid", {31'd0, tvalid}, 32'd1);
    step(99);
    push_exp(24'h001D70, 1'b0);
    push_exp(24'h00A270, 1'b1);
    pulse_tick();
    step(99);
    push_exp(24'h002C28, 1'b0);
    push_exp(24'h00B3A8, 1'b1);
    pulse_tick();
    drain();

    // Wrap: carry discarded, tag untouched
    do_reset(2);
    cfg_inc = {13'h0001, 13'h1FFF};
    for (int k = 0; k < 5; k++) begin
      push_exp({9'd0, w0[k]}, 1'b0);
      push_exp({9'd1, 15'(k + 1)}, 1'b1);
      pulse_tick();
      step(9);
    end
    drain();

    // Backpressure on the first beat
    do_reset(2);
    cfg_inc = {13'h1138, 13'h0EB8};
    tready = 1'b0;
    model_burst();
    pulse_tick();
    step(10);
    check1("bp_tdata", {8'd0, tdata}, 32'h00000EB8);
    tready = 1'b1;
    drain();

    // One queued tick: one extra burst, no overrun
    tready = 1'b0;
    model_burst();
    pulse_tick();
    step(1);
    model_burst();
    pulse_tick();
    step(2);
    check1("queue_overrun", {31'd0, overrun}, 32'd0);
    tready = 1'b1;
    drain();
    check1("queue_overrun_end", {31'd0, overrun}, 32'd0);

    // Three ticks during a burst: overrun, only one extra burst
    tready = 1'b0;
    model_burst();
    pulse_tick();
    step(1);
    model_burst();
    pulse_tick();
    step(1);
    pulse_tick();
    step(1);
    pulse_tick();
    step(1);
    check1("drop_overrun", {31'd0, overrun}, 32'd1);
    tready = 1'b1;
    drain();
    check1("overrun_sticky", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check1("overrun_clr", {31'd0, overrun}, 32'd0);

    // Drop coinciding with clear keeps overrun set
    tready = 1'b0;
    model_burst();
    pulse_tick();
    step(1);
    model_burst();
    pulse_tick();
    step(1);
    tick = 1'b1;
    overrun_clr = 1'b1;
    step(1);
    tick = 1'b0;
    overrun_clr = 1'b0;
    check1("drop_wins", {31'd0, overrun}, 32'd1);
    tready = 1'b1;
    drain();
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check1("overrun_clr2", {31'd0, overrun}, 32'd0);

    // Increment change mid-burst only affects the next advance
    tready = 1'b0;
    model_burst();
    pulse_tick();
    step(2);
    cfg_inc = {13'h0200, 13'h0100};
    step(3);
    tready = 1'b1;
    drain();
    model_burst();
    pulse_tick();
    drain();

    // Reset mid-burst abandons the burst and clears everything
    cfg_inc = {13'h1138, 13'h0EB8};
    tready = 1'b0;
    pulse_tick();
    step(1);
    pulse_tick();
    step(1);
    pulse_tick();
    step(1);
    check1("pre_rst_overrun", {31'd0, overrun}, 32'd1);
    aresetn = 1'b0;
    step(1);
    aresetn = 1'b1;
    check1("midrst_tvalid", {31'd0, tvalid}, 32'd0);
    check1("midrst_tlast", {31'd0, tlast}, 32'd0);
    check1("midrst_overrun", {31'd0, overrun}, 32'd0);
    m_acc0 = 15'd0;
    m_acc1 = 15'd0;
    step(3);
    check1("midrst_idle", {31'd0, tvalid}, 32'd0);
    tready = 1'b1;
    model_burst();
    pulse_tick();
    check1("post_rst_tdata", {8'd0, tdata}, 32'h00000EB8);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
